// File: rtl/image_bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bank_arb_pkg
// Shared definitions for image_bank_arbiter: requester identifiers, the
// requester-id type and the read-return tag carried down the pipeline.
// No ports (package). Optional feature macro used by the arbiter:
// BANK_ARB_BURST_EN (see image_bank_arbiter.sv).
// -----------------------------------------------------------------------------
package bank_arb_pkg;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_LOAD = 2'd0;
    localparam req_id_t REQ_HIST = 2'd1;
    localparam req_id_t REQ_OUT  = 2'd2;
    localparam int      NUM_REQ  = 3;

    // Read-return tag: which requester issued the read, and on which bank.
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    bank;
    } tag_t;

    // Successor in the 3-entry ring 0 -> 1 -> 2 -> 0.
    function automatic req_id_t next_id(input req_id_t id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/image_bank_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Three-way round-robin selector. Search starts just after the last granted
// requester and wraps; the first asserted candidate wins.
// Ports:
//   cand    in  3  candidate vector
//   last    in  2  previously granted requester (search starts at last+1)
//   gnt_oh  out 3  one-hot selection (all zero when no candidate)
//   gnt_id  out 2  selected requester id (meaningful only when gnt_oh != 0)
// -----------------------------------------------------------------------------
module rr_pick3
    import bank_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] cand,
    input  req_id_t            last,
    output logic [NUM_REQ-1:0] gnt_oh,
    output req_id_t            gnt_id
);

    always_comb begin
        req_id_t idx;
        idx    = last;
        gnt_oh = '0;
        gnt_id = last;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = next_id(idx);
            if ((gnt_oh == '0) && cand[idx]) begin
                gnt_oh[idx] = 1'b1;
                gnt_id      = idx;
            end
        end
    end

endmodule

// File: rtl/image_bank_arbiter.sv
// -----------------------------------------------------------------------------
// image_bank_arbiter
// Shares two ping-pong single-port image SRAM banks between LOAD (write),
// HIST (read) and OUT (read). Each bank has its own round-robin arbiter, so
// requesters on different banks are served in the same cycle. Grants are
// combinational; SRAM controls are registered one cycle later; read data
// returns to the issuer two cycles after its grant.
//
// Optional feature: define BANK_ARB_BURST_EN to let a bank owner keep its
// grant for up to BURST_LEN consecutive cycles while it keeps requesting.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   req[3], req_bank[3]     request and target bank per requester
//   req_addr[3*ADDR_W]      address per requester (i at [i*ADDR_W +: ADDR_W])
//   load_wdata              LOAD write data
//   gnt[3]                  combinational grant per requester
//   hist_/out_rvalid,rdata  read return per reading requester (rdata held)
//   mem_cs[2], mem_we[2]    registered bank chip select / write enable
//   mem_addr0/1, mem_wdata0/1  registered bank address / write data
//   mem_rdata0/1            bank read data, valid one cycle after mem_cs
// -----------------------------------------------------------------------------
module image_bank_arbiter
    import bank_arb_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_bank,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]         load_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      hist_rvalid,
    output logic                      out_rvalid,
    output logic [DATA_W-1:0]         hist_rdata,
    output logic [DATA_W-1:0]         out_rdata,
    output logic [1:0]                mem_cs,
    output logic [1:0]                mem_we,
    output logic [ADDR_W-1:0]         mem_addr0,
    output logic [ADDR_W-1:0]         mem_addr1,
    output logic [DATA_W-1:0]         mem_wdata0,
    output logic [DATA_W-1:0]         mem_wdata1,
    input  logic [DATA_W-1:0]         mem_rdata0,
    input  logic [DATA_W-1:0]         mem_rdata1
);

    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("BURST_LEN must be at least 1");
    end

    logic [1:0][NUM_REQ-1:0] cand;
    logic [1:0][1:0]         last;
    logic [1:0][1:0]         pick_last;
    logic [1:0][NUM_REQ-1:0] pick_oh;
    logic [1:0][1:0]         pick_id;
    logic [1:0][NUM_REQ-1:0] bank_gnt;
    logic [1:0][1:0]         bank_id;
    logic [1:0]              bank_any;

    logic [1:0][ADDR_W-1:0]  addr_q;
    logic [1:0][DATA_W-1:0]  wdata_q;
    tag_t [1:0]              tag_p1;
    tag_t [1:0]              tag_p2;
    logic [DATA_W-1:0]       hist_hold;
    logic [DATA_W-1:0]       out_hold;

`ifdef BANK_ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    logic [1:0]              busy;
    logic [1:0][1:0]         owner;
    logic [1:0][CNT_W-1:0]   cnt;
    logic [1:0]              keep;
`endif

    // Candidates per bank, and the pointer the round-robin search starts from.
    always_comb begin
        cand      = '0;
        pick_last = last;
`ifdef BANK_ARB_BURST_EN
        keep = '0;
`endif
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand[b][i] = req[i] && (req_bank[i] == 1'(b));
            end
`ifdef BANK_ARB_BURST_EN
            // While a burst runs the pointer is frozen; a burst that ends this
            // cycle must rotate away from its owner, so search after it.
            keep[b] = busy[b] && cand[b][owner[b]] && (cnt[b] < CNT_W'(BURST_LEN));
            if (busy[b]) begin
                pick_last[b] = owner[b];
            end
`endif
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_pick
        rr_pick3 u_pick (
            .cand   (cand[b]),
            .last   (pick_last[b]),
            .gnt_oh (pick_oh[b]),
            .gnt_id (pick_id[b])
        );
    end

    // Final per-bank grant; reset forces all grants low combinationally.
    always_comb begin
        bank_gnt = pick_oh;
        bank_id  = pick_id;
        for (int b = 0; b < 2; b++) begin
`ifdef BANK_ARB_BURST_EN
            if (keep[b]) begin
                bank_gnt[b]           = '0;
                bank_gnt[b][owner[b]] = 1'b1;
                bank_id[b]            = owner[b];
            end
`endif
            if (reset) begin
                bank_gnt[b] = '0;
            end
        end
        bank_any[0] = |bank_gnt[0];
        bank_any[1] = |bank_gnt[1];
        gnt         = bank_gnt[0] | bank_gnt[1];
    end

    // ---- stage p0 -> p1: register SRAM controls and launch read tags ----
    always_ff @(posedge clock) begin
        if (reset) begin
            last      <= {2'd2, 2'd2};
            mem_cs    <= '0;
            mem_we    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tag_p1    <= '0;
            tag_p2    <= '0;
            hist_hold <= '0;
            out_hold  <= '0;
`ifdef BANK_ARB_BURST_EN
            busy      <= '0;
            owner     <= '0;
            cnt       <= '0;
`endif
        end else begin
            for (int b = 0; b < 2; b++) begin
                mem_cs[b] <= bank_any[b];
                mem_we[b] <= bank_any[b] && (bank_id[b] == REQ_LOAD);
                if (bank_any[b]) begin
                    addr_q[b] <= req_addr[int'(bank_id[b])*ADDR_W +: ADDR_W];
                end
                if (bank_any[b] && (bank_id[b] == REQ_LOAD)) begin
                    wdata_q[b] <= load_wdata;
                end
                tag_p1[b] <= '{valid: bank_any[b] && (bank_id[b] != REQ_LOAD),
                               id:    bank_id[b],
                               bank:  1'(b)};
`ifdef BANK_ARB_BURST_EN
                if (keep[b]) begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end else begin
                    if (busy[b]) begin
                        last[b] <= owner[b];
                    end
                    busy[b]  <= bank_any[b];
                    owner[b] <= bank_any[b] ? bank_id[b] : 2'd0;
                    cnt[b]   <= bank_any[b] ? CNT_W'(1) : '0;
                end
`else
                if (bank_any[b]) begin
                    last[b] <= bank_id[b];
                end
`endif
            end
            // ---- stage p1 -> p2: tag follows the SRAM access ----
            tag_p2    <= tag_p1;
            hist_hold <= hist_rdata;
            out_hold  <= out_rdata;
        end
    end

    assign mem_addr0  = addr_q[0];
    assign mem_addr1  = addr_q[1];
    assign mem_wdata0 = wdata_q[0];
    assign mem_wdata1 = wdata_q[1];

    // ---- stage p2: steer bank read data to the issuing requester ----
    always_comb begin
        logic [DATA_W-1:0] rd;
        rd          = '0;
        hist_rvalid = 1'b0;
        out_rvalid  = 1'b0;
        hist_rdata  = hist_hold;
        out_rdata   = out_hold;
        for (int b = 0; b < 2; b++) begin
            if (tag_p2[b].valid && !reset) begin
                rd = tag_p2[b].bank ? mem_rdata1 : mem_rdata0;
                if (tag_p2[b].id == REQ_HIST) begin
                    hist_rvalid = 1'b1;
                    hist_rdata  = rd;
                end else if (tag_p2[b].id == REQ_OUT) begin
                    out_rvalid = 1'b1;
                    out_rdata  = rd;
                end
            end
        end
    end

endmodule

// File: doc/image_bank_arbiter.md
# image_bank_arbiter

Shares the two ping-pong image SRAM banks between the three pixel-memory requesters in the histogram-equalization pipeline: the external image loader (write), the histogram module (read) and the output module (read). Each bank is arbitrated independently and round-robin, so two requesters on different banks proceed in the same cycle. Read data is routed back to the issuing requester with fixed latency. The block sits between the Control-sequenced processing modules and the two single-port SRAM macros.

## Interface
Parameters:
- ADDR_W, 14, pixel address width (128x128 image)
- DATA_W, 8, pixel width
- BURST_LEN, 16, max consecutive grants held by one requester (burst mode only)

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  3  request per requester, index 0=LOAD, 1=HIST, 2=OUT
- req_bank  in  3  target bank per requester (0/1); matches image bit of HistControl/OutputControl[1]
- req_addr  in  3*ADDR_W  address per requester, requester i at [i*ADDR_W +: ADDR_W]
- load_wdata  in  DATA_W  write data, LOAD only
- gnt  out  3  grant per requester, combinational
- hist_rvalid, out_rvalid  out  1 each  read data valid
- hist_rdata, out_rdata  out  DATA_W each  read data
- mem_cs  out  2  chip select per bank, registered
- mem_we  out  2  write enable per bank, registered
- mem_addr0, mem_addr1  out  ADDR_W  bank address, registered
- mem_wdata0, mem_wdata1  out  DATA_W  bank write data, registered
- mem_rdata0, mem_rdata1  in  DATA_W  bank read data, valid 1 cycle after mem_cs

## Operation
- Per bank b: candidates = requesters with req=1 and req_bank=b. At most one gnt per bank per cycle; requesters on different banks may both be granted.
- Round-robin: per-bank pointer last[b] (2 bits). Priority order starts at last[b]+1 mod 3. On a grant, last[b] <= granted id.
- LOAD grant: mem_we[b]=1, write load_wdata. HIST/OUT grant: mem_we[b]=0 read.
- Requester holds req/req_bank/req_addr stable until it sees gnt. It may present the next access in the following cycle.
- Tag pipeline, 2 stages: {valid, requester id, bank}. Stage 2 steers mem_rdata<bank> to hist_rdata or out_rdata and pulses the matching rvalid. LOAD grants produce no rvalid.
- hist_rdata/out_rdata hold their last value when rvalid=0.
- req with req_bank changing while ungranted: re-evaluated every cycle, no penalty.
- Reset: gnt=0 (combinationally, while reset=1), mem_cs=0, mem_we=0, mem_addr*/mem_wdata*=0, rvalid=0, rdata=0, last[b]=2 so LOAD has first priority. Tag pipeline is flushed: reads in flight at reset never return rvalid.

## Timing
- Cycle N: req and gnt in the same cycle.
- Cycle N+1: mem_cs/mem_we/mem_addr/mem_wdata drive the SRAM.
- Cycle N+2: rvalid and rdata at the requester. Read latency is 2 cycles from gnt.
- Throughput: 1 access per bank per cycle, i.e. 2 accesses per cycle across both banks.
- Fairness: a continuously requesting requester waits at most 2 grant slots on its bank (2*BURST_LEN in burst mode).

## Configuration
- BANK_ARB_BURST_EN defined:
  - Per-bank burst counter (log2(BURST_LEN)+1 bits).
  - The current owner keeps the grant while its req stays high on that bank, up to BURST_LEN consecutive grants.
  - The pointer is not advanced until the burst ends, i.e. the owner drops req, moves to the other bank, or the count reaches BURST_LEN. At that point last[b] <= owner and the counter clears.
- Not defined: pure per-cycle round-robin; the pointer advances on every grant. No counter logic is present.

## Structure
- Package bank_arb_pkg holds:
  - localparams REQ_LOAD=0, REQ_HIST=1, REQ_OUT=2, NUM_REQ=3
  - typedef req_id_t (2 bits)
  - typedef tag_t {valid, req_id_t id, bank}
- Sub-module rr_pick3: 3-way round-robin selector (inputs: candidate vector, last pointer; outputs: one-hot grant and id). Instantiated once per bank.

## Test plan
- Reset then LOAD writes addr 0x0005 data 0xA7 to bank0, then HIST reads bank0 addr 0x0005 -> hist_rvalid=1 with 0xA7 exactly 2 cycles after the HIST gnt.
- HIST on bank0 and OUT on bank1 in the same cycle -> both gnt=1 that cycle, both rvalid 2 cycles later with the correct bank's data.
- LOAD, HIST and OUT all hold req to bank1, burst off -> grants rotate LOAD, HIST, OUT, LOAD… with one grant per cycle and no gaps.
- Same as above with BANK_ARB_BURST_EN, BURST_LEN=4 -> LOAD granted 4 cycles, then HIST 4, then OUT 4.
- Assert reset one cycle after a HIST gnt -> no hist_rvalid, mem_cs=0 next cycle, and LOAD wins the first post-reset contention.
- OUT requests bank0 and then switches req_bank to bank1 while ungranted because LOAD owns bank0 -> OUT is granted on bank1 the cycle it switches.
